// File: rtl/genius_controller_if.sv
// Handshake bundle between the Genius game controller and its datapath:
// status flags and the confirm button in, reset/enable/select strobes out.
interface genius_controller_if;
    logic       enter;
    logic       end_FPGA;
    logic       end_User;
    logic       end_time;
    logic       win;
    logic       match;
    logic       R1;
    logic       R2;
    logic       E1;
    logic       E2;
    logic       E3;
    logic       E4;
    logic       SEL;
    logic [2:0] state;

    modport master (
        input  enter, end_FPGA, end_User, end_time, win, match,
        output R1, R2, E1, E2, E3, E4, SEL, state
    );

    modport slave (
        output enter, end_FPGA, end_User, end_time, win, match,
        input  R1, R2, E1, E2, E3, E4, SEL, state
    );
endinterface

// File: rtl/genius_controller.sv
// Moore control FSM for the Genius (Simon) game. All strobes are registered
// and decoded from the next state so they line up with the state register.
module genius_controller #(
    parameter int unsigned CHECK_WAIT = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    genius_controller_if.master bus
);

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        SETUP      = 3'd1,
        CLEAR      = 3'd2,
        SEQUENCE   = 3'd3,
        PLAY       = 3'd4,
        CHECK      = 3'd5,
        NEXT_ROUND = 3'd6,
        RESULT     = 3'd7
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(CHECK_WAIT - 1);

    state_e     state_q, state_d;
    logic       enter_q, enter_d;
    logic       enter_rise;
    logic [3:0] wait_q, wait_d;
    logic       r1_q, r1_d, r2_q, r2_d, sel_q, sel_d;
    logic       e1_q, e1_d, e2_q, e2_d, e3_q, e3_d, e4_q, e4_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= INIT;
            // Held high so a button kept pressed through reset is not an edge.
            enter_q <= 1'b1;
            wait_q  <= '0;
            r1_q    <= 1'b1;
            r2_q    <= 1'b1;
            e1_q    <= 1'b0;
            e2_q    <= 1'b0;
            e3_q    <= 1'b0;
            e4_q    <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            wait_q  <= wait_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            e3_q    <= e3_d;
            e4_q    <= e4_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        enter_d    = bus.enter;
        enter_rise = bus.enter & ~enter_q;
        state_d    = state_q;
        wait_d     = wait_q;
        case (state_q)
            INIT:       state_d = SETUP;
            SETUP:      if (enter_rise) state_d = CLEAR;
            CLEAR:      state_d = SEQUENCE;
            SEQUENCE:   if (bus.end_FPGA) state_d = PLAY;
            PLAY: begin
                if (bus.end_User) begin
                    state_d = CHECK;
                    wait_d  = WAIT_LOAD;
                end else if (bus.end_time) begin
                    state_d = RESULT;
                end
            end
            CHECK: begin
                if (wait_q == 4'd0) begin
                    if (!bus.match || bus.win) state_d = RESULT;
                    else                       state_d = NEXT_ROUND;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            NEXT_ROUND: state_d = CLEAR;
            RESULT:     if (enter_rise) state_d = INIT;
            default:    state_d = INIT;
        endcase
    end

    always_comb begin
        r1_d  = 1'b0;
        r2_d  = 1'b0;
        e1_d  = 1'b0;
        e2_d  = 1'b0;
        e3_d  = 1'b0;
        e4_d  = 1'b0;
        sel_d = 1'b0;
        case (state_d)
            INIT: begin
                r1_d = 1'b1;
                r2_d = 1'b1;
            end
            SETUP:      e1_d  = 1'b1;
            CLEAR:      r2_d  = 1'b1;
            SEQUENCE:   e3_d  = 1'b1;
            PLAY:       e2_d  = 1'b1;
            NEXT_ROUND: e4_d  = 1'b1;
            RESULT:     sel_d = 1'b1;
            default:    ;
        endcase
    end

    assign bus.R1    = r1_q;
    assign bus.R2    = r2_q;
    assign bus.E1    = e1_q;
    assign bus.E2    = e2_q;
    assign bus.E3    = e3_q;
    assign bus.E4    = e4_q;
    assign bus.SEL   = sel_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_genius_controller.sv
// Self-checking bench for genius_controller: directed game walk-through, then
// randomized play compared each cycle against a behavioural game model.
module tb_genius_controller;

    localparam int unsigned CHECK_WAIT = 2;

    logic clk;
    logic reset;
    genius_controller_if bus ();

    genius_controller #(.CHECK_WAIT(CHECK_WAIT)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Game model: phase numbers follow the debug code table of the controller.
    int unsigned m_phase     = 0;
    bit          m_btn_prev  = 1'b1;
    int unsigned m_check_cnt = 0;

    // {R1,R2,E1,E2,E3,E4,SEL} expected while the game is in a given phase.
    function automatic logic [6:0] phase_strobes(input int unsigned ph);
        case (ph)
            0:       return 7'b1100000;
            1:       return 7'b0010000;
            2:       return 7'b0100000;
            3:       return 7'b0000100;
            4:       return 7'b0001000;
            6:       return 7'b0000010;
            7:       return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_step(input bit rst, en, fp, us, tm, mt, wn);
        bit press;
        press      = en && !m_btn_prev;
        m_btn_prev = rst ? 1'b1 : en;
        if (rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: if (press) m_phase = 2;
                2: m_phase = 3;
                3: if (fp) m_phase = 4;
                4: begin
                    if (us) begin
                        m_phase     = 5;
                        m_check_cnt = 1;
                    end else if (tm) begin
                        m_phase = 7;
                    end
                end
                5: begin
                    if (m_check_cnt >= CHECK_WAIT) m_phase = (!mt || wn) ? 7 : 6;
                    else m_check_cnt++;
                end
                6: m_phase = 2;
                7: if (press) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic cycle(input bit rst, en, fp, us, tm, mt, wn);
        @(negedge clk);
        reset        = rst;
        bus.enter    = en;
        bus.end_FPGA = fp;
        bus.end_User = us;
        bus.end_time = tm;
        bus.match    = mt;
        bus.win      = wn;
        @(posedge clk);
        model_step(rst, en, fp, us, tm, mt, wn);
        #1;
        check("state", 32'(bus.state), 32'(m_phase));
        check("strobes", 32'({bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL}),
              32'(phase_strobes(m_phase)));
        check("e_excl", 32'($countones({bus.E1, bus.E2, bus.E3, bus.E4}) <= 1), 32'd1);
        check("r2_excl", 32'(bus.R2 & (bus.E2 | bus.E3)), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.enter    = 1'b1;
        bus.end_FPGA = 1'b0;
        bus.end_User = 1'b0;
        bus.end_time = 1'b0;
        bus.match    = 1'b0;
        bus.win      = 1'b0;

        // Reset with enter held, release, enter must not count until re-pressed
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        check("t1_init_r1r2", 32'({bus.R1, bus.R2}), 32'b11);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("t1_setup", 32'(bus.state), 32'd1);
        repeat (3) cycle(0, 1, 0, 0, 0, 0, 0);
        check("t1_hold", 32'(bus.state), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("t2_clear", 32'(bus.state), 32'd2);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("t2_seq", 32'(bus.state), 32'd3);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("t2_play_e2", 32'(bus.E2), 32'd1);

        // Successful round, not final
        cycle(0, 0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 1, 0, 1, 0);
        check("t3_check2", 32'(bus.state), 32'd5);
        cycle(0, 0, 0, 1, 0, 1, 0);
        check("t3_next_e4", 32'(bus.E4), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("t3_seq", 32'(bus.state), 32'd3);
        cycle(0, 0, 1, 0, 0, 0, 0);

        // Timeout to result screen, then back to INIT
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("t4_sel", 32'(bus.SEL), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("t4_init", 32'(bus.state), 32'd0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);

        // end_User beats end_time; final round wins
        cycle(0, 0, 0, 1, 1, 1, 1);
        check("t5_prio", 32'(bus.state), 32'd5);
        cycle(0, 0, 0, 1, 1, 1, 1);
        cycle(0, 0, 0, 1, 1, 1, 1);
        check("t5_result", 32'(bus.state), 32'd7);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("t6_seq_e3", 32'(bus.E3), 32'd1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("t6_reset", 32'(bus.state), 32'd0);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 149) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/genius_controller.md
Name: genius_controller

Overview:
- Control FSM for the Genius (Simon) game; sits directly upstream of the game datapath.
- Drives the datapath's reset/enable/select strobes (R1, R2, E1–E4, SEL).
- Consumes its status flags (end_FPGA, end_User, end_time, win, match) and the player's confirm button.
- Sequences the game: setup → FPGA plays sequence → user repeats → compare → next round or result screen.

Parameters:
- CHECK_WAIT, 2: cycles spent in CHECK before sampling match/win; covers the datapath's register-to-compare path. Legal range 1–15.

Ports:
- CLOCK_50  in   1  system clock, all logic on rising edge
- reset     in   1  synchronous, active-high; forces INIT
- enter     in   1  confirm button, level, active-high; already synchronised upstream
- end_FPGA  in   1  FPGA sequence playback complete
- end_User  in   1  user has entered as many symbols as the current round
- end_time  in   1  user input timer expired
- win       in   1  final round reached for the selected level
- match     in   1  user sequence equals FPGA sequence; valid while end_User is high
- R1        out  1  global reset of setup/round registers
- R2        out  1  per-round reset of timer/user/FPGA counters and registers
- E1        out  1  setup register load enable
- E2        out  1  user phase enable (timer + user input capture)
- E3        out  1  FPGA sequence playback enable
- E4        out  1  round counter increment
- SEL       out  1  display select: 0 = game info, 1 = result screen
- state     out  3  current state code, for debug LEDs

Behaviour:

Structure:
- Moore FSM. State register and all outputs are registered.
- Outputs are decoded from the next state, so each output is valid in the same cycle the state register shows that state.

Reset:
- Synchronous reset gives: state=INIT (0), R1=1, R2=1, E1..E4=0, SEL=0.
- The internal enter_q register is set to 1. This prevents a spurious edge when enter is held through reset.

Enter edge:
- enter_rise = enter & ~enter_q.
- enter_q <= enter every cycle.
- Only enter_rise causes transitions; holding enter produces one event.

States (code: outputs high; transitions):
- INIT (0): R1, R2 high. Next cycle goes to SETUP unconditionally.
- SETUP (1): E1 high. Stays until enter_rise, then goes to CLEAR.
- CLEAR (2): R2 high for exactly one cycle. Then goes to SEQUENCE.
- SEQUENCE (3): E3 high. Stays until end_FPGA=1, then goes to PLAY.
- PLAY (4): E2 high.
  - end_User=1 goes to CHECK.
  - Else end_time=1 goes to RESULT.
  - If both are high in the same cycle, end_User has priority.
- CHECK (5): no strobes. Internal wait counter loads CHECK_WAIT-1 on entry and decrements. When it reaches 0, sample inputs:
  - match=0 goes to RESULT (loss).
  - match=1 and win=1 goes to RESULT (win).
  - match=1 and win=0 goes to NEXT_ROUND.
- NEXT_ROUND (6): E4 high for exactly one cycle. Then goes to CLEAR.
- RESULT (7): SEL high. Datapath selects win/lose text from its own win flag. Stays until enter_rise, then goes to INIT.

Timing and boundary rules:
- Condition to transition latency: condition sampled at edge k, new state and outputs visible after edge k.
- At most one of E1..E4 is high in any cycle. R2 is never high together with E2 or E3.
- reset takes priority over every transition, including mid-SEQUENCE, mid-PLAY and mid-CHECK. A reset in any state returns to INIT on the next edge.
- enter_rise is ignored in every state except SETUP and RESULT.
- end_FPGA is ignored outside SEQUENCE. end_User, end_time, match and win are ignored outside PLAY/CHECK as specified above.
- The CHECK wait counter (4 bits) is reloaded on every CHECK entry and never wraps.

Test Plan:
1. reset=1 for 2 cycles, then release with enter held high → state=0 then 1; R1=R2=1 in INIT, E1=1 in SETUP; no transition until enter falls and rises again.
2. SETUP, enter pulse 1 cycle → CLEAR for exactly 1 cycle with R2=1 → SEQUENCE with E3=1; end_FPGA pulse → PLAY with E2=1 on the next cycle.
3. PLAY, end_User=1, match=1, win=0, CHECK_WAIT=2 → CHECK for 2 cycles → NEXT_ROUND with E4=1 for 1 cycle → CLEAR → SEQUENCE.
4. PLAY, end_time=1 → RESULT with SEL=1, all E=0; enter rise → INIT with R1=R2=1.
5. PLAY, end_User=1 and end_time=1 in the same cycle, match=1, win=1 → CHECK (not RESULT) → RESULT after CHECK_WAIT cycles.
6. Assert reset for one cycle while in SEQUENCE with E3=1 → next cycle state=0, E3=0, R1=R2=1. Across a full random game, check every cycle that at most one of E1..E4 is high.
